// File: rtl/if_stage_fetch_q_pkg.sv
// Shared widths, constants and bus layout helpers for the fetch stage.
// The decode bus is packed as {adef, pc, inst}, inst in the low bits.
package if_stage_fetch_q_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;
  localparam int          PC_STEP          = 4;

  function automatic int fs_to_ds_bus_wd(input int pc_w, input int inst_w);
    return 1 + pc_w + inst_w;
  endfunction

  function automatic int br_bus_wd(input int pc_w);
    return 1 + pc_w;
  endfunction

  function automatic int bus_pc_lsb(input int inst_w);
    return inst_w;
  endfunction

  function automatic int bus_adef_bit(input int pc_w, input int inst_w);
    return pc_w + inst_w;
  endfunction

endpackage

// File: rtl/if_stage_fetch_q_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2.
// Flush wins over push and pop in the same cycle.
module if_stage_fetch_q_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !i_flush && !o_empty;
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Writing a full FIFO without a simultaneous pop means the credit scheme broke.
  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && !w_pop && o_full));

endmodule

// File: rtl/if_stage_fetch_q.sv
// Fetch stage with multiple outstanding sram-like requests, in-order responses,
// an instruction buffer toward decode and redirect/stale-response handling.
module if_stage_fetch_q
  import if_stage_fetch_q_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEFAULT),
  parameter int              IBUF_DEPTH = 4,
  parameter int              INST_W     = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ds_allow_in,
  output logic                     fs_to_ds_valid,
  output logic [PC_W+INST_W:0]     fs_to_ds_bus,
  input  logic                     br_taken,
  input  logic [PC_W-1:0]          br_target,
  output logic                     inst_sram_req,
  output logic                     inst_sram_wr,
  output logic [1:0]               inst_sram_size,
  output logic [PC_W-1:0]          inst_sram_addr,
  output logic [31:0]              inst_sram_wdata,
  input  logic                     inst_sram_addr_ok,
  input  logic                     inst_sram_data_ok,
  input  logic [INST_W-1:0]        inst_sram_rdata
);

  localparam int CW    = $clog2(IBUF_DEPTH) + 1;
  localparam int BUS_W = fs_to_ds_bus_wd(PC_W, INST_W);

  logic [PC_W-1:0]  r_fetch_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_discard;
  logic             r_adef_pend;
  logic             r_adef_done;

  logic [CW:0]      w_inflight;
  logic             w_req;
  logic             w_hs;
  logic [CW-1:0]    w_out_after_rsp;
  logic             w_data_push;
  logic             w_adef_push;
  logic             w_ib_push;
  logic             w_ib_pop;
  logic [BUS_W-1:0] w_ib_wdata;
  logic [BUS_W-1:0] w_ib_rdata;
  logic [CW-1:0]    w_ib_count;
  logic             w_ib_full;
  logic             w_ib_empty;
  logic [PC_W-1:0]  w_tag_pc;
  logic [CW-1:0]    w_tag_count;
  logic             w_tag_full;
  logic             w_tag_empty;

  // Outstanding requests (stale ones included) plus buffered entries never exceed the buffer.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_ib_count};
  assign w_req      = resetn && !br_taken && !r_adef_pend
                      && (w_inflight < (CW+1)'(IBUF_DEPTH));
  assign w_hs       = w_req && inst_sram_addr_ok;

  assign inst_sram_req   = w_req;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_wdata = 32'h0;

  assign w_out_after_rsp = r_outstanding - CW'(inst_sram_data_ok);
  assign w_data_push     = inst_sram_data_ok && (r_discard == '0) && !br_taken;
  assign w_adef_push     = r_adef_pend && !r_adef_done && (r_outstanding == '0)
                           && !w_ib_full && !br_taken;
  assign w_ib_push       = w_data_push || w_adef_push;
  assign w_ib_wdata      = w_adef_push ? {1'b1, r_fetch_pc, {INST_W{1'b0}}}
                                       : {1'b0, w_tag_pc, inst_sram_rdata};

  assign fs_to_ds_valid = !w_ib_empty && !br_taken;
  assign fs_to_ds_bus   = w_ib_rdata;
  assign w_ib_pop       = fs_to_ds_valid && ds_allow_in;

  if_stage_fetch_q_fifo #(.WIDTH(BUS_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk     (clk),
    .rst_n   (resetn),
    .i_flush (br_taken),
    .i_push  (w_ib_push),
    .i_pop   (w_ib_pop),
    .i_wdata (w_ib_wdata),
    .o_rdata (w_ib_rdata),
    .o_count (w_ib_count),
    .o_full  (w_ib_full),
    .o_empty (w_ib_empty)
  );

  // Tags survive redirects: every in-flight response still has to be matched and popped.
  if_stage_fetch_q_fifo #(.WIDTH(PC_W), .DEPTH(IBUF_DEPTH)) u_tag (
    .clk     (clk),
    .rst_n   (resetn),
    .i_flush (1'b0),
    .i_push  (w_hs),
    .i_pop   (inst_sram_data_ok),
    .i_wdata (r_fetch_pc),
    .o_rdata (w_tag_pc),
    .o_count (w_tag_count),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_adef_pend   <= 1'b0;
      r_adef_done   <= 1'b0;
    end else begin
      r_outstanding <= w_out_after_rsp + CW'(w_hs);
      if (br_taken) begin
        r_fetch_pc  <= br_target;
        r_discard   <= w_out_after_rsp;
        r_adef_pend <= |br_target[1:0];
        r_adef_done <= 1'b0;
      end else begin
        if (w_hs) r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
        if (inst_sram_data_ok && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_adef_push) r_adef_done <= 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!resetn) w_tag_count == r_outstanding);
  assert property (@(posedge clk) disable iff (!resetn) !(inst_sram_data_ok && w_tag_empty));
  assert property (@(posedge clk) disable iff (!resetn)
                   !(w_hs && w_tag_full && !inst_sram_data_ok));

endmodule

// File: tb/tb_if_stage_fetch_q.sv
// Directed and randomised checks of the fetch stage against a small sram model
// and hand-derived PC sequences.
module tb_if_stage_fetch_q;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk;
  logic        resetn;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory model controls and records
  bit mem_rand = 0;
  bit aok_en   = 1;
  bit hold_new = 0;
  typedef struct {
    logic [31:0] addr;
    int          dly;
    bit          hold;
  } mem_ent_t;
  mem_ent_t    mem_q[$];
  logic [31:0] hs_q[$];
  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];

  if_stage_fetch_q dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allow_in       (ds_allow_in),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // sram model: drives acks at posedge+2, commits the upcoming edge's events at negedge
  initial begin
    mem_ent_t e;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (!resetn) begin
        mem_q.delete();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
      end else begin
        inst_sram_addr_ok = mem_rand ? (aok_en && ($urandom_range(0, 1) == 1)) : aok_en;
        if (mem_q.size() > 0 && mem_q[0].dly == 0 && !mem_q[0].hold) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = inst_of(mem_q[0].addr);
        end else begin
          inst_sram_data_ok = 1'b0;
          inst_sram_rdata   = 32'h0;
        end
      end
      @(negedge clk);
      if (resetn) begin
        if (inst_sram_data_ok) void'(mem_q.pop_front());
        foreach (mem_q[i]) if (mem_q[i].dly > 0) mem_q[i].dly--;
        if (inst_sram_req && inst_sram_addr_ok) begin
          e.addr = inst_sram_addr;
          e.dly  = mem_rand ? int'($urandom_range(0, 5)) : 0;
          e.hold = hold_new;
          mem_q.push_back(e);
          hs_q.push_back(inst_sram_addr);
        end
        if (fs_to_ds_valid && ds_allow_in) got_q.push_back(fs_to_ds_bus);
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic allow);
    cyc();
    resetn = 1'b0; br_taken = 1'b0; br_target = 32'h0; ds_allow_in = allow;
    mem_rand = 0; aok_en = 1; hold_new = 0;
    cyc(); cyc();
    hs_q.delete(); got_q.delete();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    repeat (6) cyc();
    #2;
    n_cmp++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: got %b exp 1", fs_to_ds_valid); end
    cyc();
    resetn = 1'b0;
    #2;
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", inst_sram_req); end
    n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", fs_to_ds_valid); end
    n_cmp++; if (inst_sram_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h exp %h", inst_sram_addr, RPC); end
    n_cmp++; if ({inst_sram_wr, inst_sram_size, inst_sram_wdata} !== {1'b0, 2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_consts: got %b %b %h exp 0 10 0", inst_sram_wr, inst_sram_size, inst_sram_wdata);
    end
    cyc();
  endtask

  task automatic test_stream();
    logic [64:0] e;
    do_reset(1'b1);
    #2;
    n_cmp++; if ({inst_sram_req, inst_sram_addr} !== {1'b1, RPC}) begin
      n_fail++; $display("FAIL stream_first_req: got %b %h exp 1 %h", inst_sram_req, inst_sram_addr, RPC);
    end
    cyc(); #2;
    n_cmp++; if ({fs_to_ds_valid, inst_sram_addr} !== {1'b0, RPC + 32'd4}) begin
      n_fail++; $display("FAIL stream_second: got %b %h exp 0 %h", fs_to_ds_valid, inst_sram_addr, RPC + 32'd4);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(); #2;
      e = {1'b0, RPC + 32'(4 * k), inst_of(RPC + 32'(4 * k))};
      n_cmp++; if ({fs_to_ds_valid, fs_to_ds_bus} !== {1'b1, e}) begin
        n_fail++; $display("FAIL stream_deliver%0d: got %b %h exp 1 %h", k, fs_to_ds_valid, fs_to_ds_bus, e);
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    repeat (10) cyc();
    #2;
    n_cmp++; if (hs_q.size() !== 4) begin n_fail++; $display("FAIL stall_hs_count: got %0d exp 4", hs_q.size()); end
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b exp 0", inst_sram_req); end
    n_cmp++; if (fs_to_ds_bus[63:32] !== RPC) begin n_fail++; $display("FAIL stall_head: got %h exp %h", fs_to_ds_bus[63:32], RPC); end
    cyc();
    ds_allow_in = 1'b1;
    repeat (12) cyc();
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, RPC + 32'(4 * k), inst_of(RPC + 32'(4 * k))});
    n_cmp++; if (got_q.size() < 8) begin n_fail++; $display("FAIL stall_drain_count: got %0d exp >=8", got_q.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall_order%0d: got %h exp %h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_redirect();
    int gsz;
    int hsz;
    int n;
    do_reset(1'b1);
    n = 0;
    while (hs_q.size() < 4 && n < 40) begin cyc(); n++; end
    hold_new = 1;
    while (hs_q.size() < 6 && n < 80) begin cyc(); n++; end
    aok_en = 0;
    n_cmp++; if (n >= 80) begin n_fail++; $display("FAIL redir_timeout: got %0d handshakes exp 6", hs_q.size()); end
    repeat (4) cyc();
    br_taken = 1'b1; br_target = RPC + 32'h100;
    #2;
    gsz = got_q.size(); hsz = hs_q.size();
    n_cmp++; if ({inst_sram_req, fs_to_ds_valid} !== 2'b00) begin
      n_fail++; $display("FAIL redir_br_cycle: got req %b valid %b exp 0 0", inst_sram_req, fs_to_ds_valid);
    end
    n_cmp++; if (hsz < 6 || hs_q[4] !== RPC + 32'h10 || hs_q[5] !== RPC + 32'h14) begin
      n_fail++; $display("FAIL redir_inflight: got %0d handshakes exp 6 ending 0x1c000010 0x1c000014", hsz);
    end
    n_cmp++; if (gsz !== 4) begin n_fail++; $display("FAIL redir_pre_count: got %0d exp 4", gsz); end
    cyc();
    br_taken = 1'b0; aok_en = 1; hold_new = 0;
    foreach (mem_q[i]) mem_q[i].hold = 0;
    #2;
    n_cmp++; if ({fs_to_ds_valid, inst_sram_req, inst_sram_addr} !== {1'b0, 1'b1, RPC + 32'h100}) begin
      n_fail++; $display("FAIL redir_next_req: got %b %b %h exp 0 1 %h", fs_to_ds_valid, inst_sram_req, inst_sram_addr, RPC + 32'h100);
    end
    repeat (10) cyc();
    n_cmp++; if (got_q.size() < gsz + 2) begin n_fail++; $display("FAIL redir_post_count: got %0d exp >=%0d", got_q.size(), gsz + 2); end
    else begin
      n_cmp++; if (got_q[gsz] !== {1'b0, RPC + 32'h100, inst_of(RPC + 32'h100)}) begin
        n_fail++; $display("FAIL redir_first: got %h exp pc %h", got_q[gsz], RPC + 32'h100);
      end
      n_cmp++; if (got_q[gsz + 1] !== {1'b0, RPC + 32'h104, inst_of(RPC + 32'h104)}) begin
        n_fail++; $display("FAIL redir_second: got %h exp pc %h", got_q[gsz + 1], RPC + 32'h104);
      end
    end
  endtask

  task automatic test_br_collide();
    int gsz;
    int hsz;
    do_reset(1'b1);
    repeat (5) cyc();
    cyc();
    br_taken = 1'b1; br_target = RPC + 32'h300;
    #2;
    gsz = got_q.size(); hsz = hs_q.size();
    n_cmp++; if ({inst_sram_data_ok, inst_sram_addr_ok, inst_sram_req} !== 3'b110) begin
      n_fail++; $display("FAIL collide_cycle: got dok %b aok %b req %b exp 1 1 0", inst_sram_data_ok, inst_sram_addr_ok, inst_sram_req);
    end
    cyc();
    br_taken = 1'b0;
    #2;
    n_cmp++; if ({inst_sram_req, inst_sram_addr} !== {1'b1, RPC + 32'h300}) begin
      n_fail++; $display("FAIL collide_next_req: got %b %h exp 1 %h", inst_sram_req, inst_sram_addr, RPC + 32'h300);
    end
    repeat (6) cyc();
    n_cmp++; if (got_q.size() <= gsz || got_q[gsz] !== {1'b0, RPC + 32'h300, inst_of(RPC + 32'h300)}) begin
      n_fail++; $display("FAIL collide_first_delivery: got %0d entries, exp first new pc %h", got_q.size() - gsz, RPC + 32'h300);
    end
    n_cmp++; if (hs_q.size() <= hsz || hs_q[hsz] !== RPC + 32'h300) begin
      n_fail++; $display("FAIL collide_hs: got %0d new handshakes, exp first addr %h", hs_q.size() - hsz, RPC + 32'h300);
    end
  endtask

  task automatic test_adef();
    int gsz;
    int hsz;
    do_reset(1'b1);
    repeat (5) cyc();
    cyc();
    br_taken = 1'b1; br_target = RPC + 32'h102;
    #2;
    gsz = got_q.size(); hsz = hs_q.size();
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL adef_br_req: got %b exp 0", inst_sram_req); end
    cyc();
    br_taken = 1'b0;
    #2;
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL adef_stall_req: got %b exp 0", inst_sram_req); end
    repeat (8) cyc();
    n_cmp++; if (hs_q.size() !== hsz) begin n_fail++; $display("FAIL adef_no_fetch: got %0d exp %0d", hs_q.size(), hsz); end
    n_cmp++; if (got_q.size() !== gsz + 1) begin n_fail++; $display("FAIL adef_one_entry: got %0d exp %0d", got_q.size(), gsz + 1); end
    else begin
      n_cmp++; if (got_q[gsz] !== {1'b1, RPC + 32'h102, 32'h0}) begin
        n_fail++; $display("FAIL adef_entry: got %h exp %h", got_q[gsz], {1'b1, RPC + 32'h102, 32'h0});
      end
    end
    br_taken = 1'b1; br_target = RPC + 32'h200;
    cyc();
    br_taken = 1'b0;
    #2;
    n_cmp++; if ({inst_sram_req, inst_sram_addr} !== {1'b1, RPC + 32'h200}) begin
      n_fail++; $display("FAIL adef_resume_req: got %b %h exp 1 %h", inst_sram_req, inst_sram_addr, RPC + 32'h200);
    end
    repeat (6) cyc();
    n_cmp++; if (got_q.size() < gsz + 2 || got_q[gsz + 1] !== {1'b0, RPC + 32'h200, inst_of(RPC + 32'h200)}) begin
      n_fail++; $display("FAIL adef_resume_delivery: got %0d entries, exp next pc %h", got_q.size(), RPC + 32'h200);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [64:0] e;
    int          ndel;
    do_reset(1'b0);
    mem_rand = 1;
    exp_pc = RPC;
    ndel = 0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      br_taken = 1'b0;
      ds_allow_in = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) begin
        br_taken = 1'b1;
        br_target = 32'h1c001000 + ($urandom_range(0, 255) << 2);
      end
      #2;
      if (br_taken) begin
        n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL rand_valid_on_br: got %b exp 0", fs_to_ds_valid); end
        exp_pc = br_target;
      end else if (fs_to_ds_valid && ds_allow_in) begin
        e = {1'b0, exp_pc, inst_of(exp_pc)};
        n_cmp++; if (fs_to_ds_bus !== e) begin n_fail++; $display("FAIL rand_delivery: got %h exp %h", fs_to_ds_bus, e); end
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
    end
    cyc();
    br_taken = 1'b0; ds_allow_in = 1'b1; mem_rand = 0;
    n_cmp++; if (ndel < 50) begin n_fail++; $display("FAIL rand_progress: got %0d deliveries exp >=50", ndel); end
  endtask

  initial begin
    resetn = 1'b0; ds_allow_in = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_br_collide();
    test_adef();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
